// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the five-stage RISC-V pipeline.
// Owns the PC, drives the instruction memory address and fills the IF/ID
// register. Stalls hold everything; EX redirects load a new PC and flush
// IF/ID to a bubble.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirects go to
// TRAP_PC and are reported on Misaligned_Fetch / Fault_Addr). Without it the
// redirect target is simply word-aligned.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [63:0] TRAP_PC   = 64'h0000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] Instruction_Address,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Misaligned_Fetch,
  output logic [63:0] Fault_Addr
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic [63:0] pc_q, pc_d;
  logic [63:0] ifidPc_q, ifidPc_d;
  logic [31:0] ifidInstr_q, ifidInstr_d;
  logic        ifidValid_q, ifidValid_d;
  logic        misaligned_q, misaligned_d;
  logic [63:0] faultAddr_q, faultAddr_d;

  // Next-state selection: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pc_d         = pc_q;
    ifidPc_d     = ifidPc_q;
    ifidInstr_d  = ifidInstr_q;
    ifidValid_d  = ifidValid_q;
    misaligned_d = 1'b0;
    faultAddr_d  = faultAddr_q;
    if (Branch_Taken) begin
      ifidPc_d    = 64'h0;
      ifidInstr_d = NOP_INSTR;
      ifidValid_d = 1'b0;
      if (TrapEn && (Branch_Target[1:0] != 2'b00)) begin
        pc_d         = TRAP_PC;
        misaligned_d = 1'b1;
        faultAddr_d  = Branch_Target;
      end else begin
        pc_d = {Branch_Target[63:2], 2'b00};
      end
    end else if (!Stall) begin
      ifidPc_d    = pc_q;
      ifidInstr_d = Instruction;
      ifidValid_d = 1'b1;
      pc_d        = pc_q + 64'd4;
    end
  end

  // State registers; reset clears IF/ID to a bubble and restarts at RESET_PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      ifidPc_q     <= 64'h0;
      ifidInstr_q  <= NOP_INSTR;
      ifidValid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      faultAddr_q  <= 64'h0;
    end else begin
      pc_q         <= pc_d;
      ifidPc_q     <= ifidPc_d;
      ifidInstr_q  <= ifidInstr_d;
      ifidValid_q  <= ifidValid_d;
      misaligned_q <= misaligned_d;
      faultAddr_q  <= faultAddr_d;
    end
  end

  assign Instruction_Address = pc_q;
  assign IFID_PC             = ifidPc_q;
  assign IFID_Instruction    = ifidInstr_q;
  assign IFID_Valid          = ifidValid_q;
  assign Misaligned_Fetch    = misaligned_q;
  assign Fault_Addr          = faultAddr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A driver issues one
// control transaction per cycle and pushes the architecturally expected state
// into a queue; an independent monitor pops and compares after each edge.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] TRAP_PC   = 64'h0000_0000_0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TrapMode = 1'b1;
`else
  localparam bit TrapMode = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] Instruction_Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Branch_Taken;
  logic [63:0] Branch_Target;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic        Misaligned_Fetch;
  logic [63:0] Fault_Addr;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ifidPc;
    logic [31:0] ifidInstr;
    logic        ifidValid;
    logic        mis;
    logic [63:0] fault;
  } expT;

  expT expQ[$];

  // Architectural reference state
  logic [63:0] mPc;
  logic [63:0] mIfidPc;
  logic [31:0] mIfidInstr;
  logic        mIfidValid;
  logic [63:0] mFault;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .TRAP_PC  (TRAP_PC)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .Instruction_Address(Instruction_Address),
    .Instruction        (Instruction),
    .Stall              (Stall),
    .Branch_Taken       (Branch_Taken),
    .Branch_Target      (Branch_Target),
    .IFID_PC            (IFID_PC),
    .IFID_Instruction   (IFID_Instruction),
    .IFID_Valid         (IFID_Valid),
    .Misaligned_Fetch   (Misaligned_Fetch),
    .Fault_Addr         (Fault_Addr)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[31:0] * 32'h0019_660D) ^ a[63:32] ^ 32'hDEAD_0000;
  endfunction

  assign Instruction = memWord(Instruction_Address);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic expT snapshot(input logic mis);
    expT e;
    e.pc        = mPc;
    e.ifidPc    = mIfidPc;
    e.ifidInstr = mIfidInstr;
    e.ifidValid = mIfidValid;
    e.mis       = mis;
    e.fault     = mFault;
    return e;
  endfunction

  task automatic modelReset();
    mPc        = RESET_PC;
    mIfidPc    = 64'h0;
    mIfidInstr = NOP_INSTR;
    mIfidValid = 1'b0;
    mFault     = 64'h0;
  endtask

  // One pipeline step of the reference: what the front end should hold after this edge
  task automatic modelStep(input logic s, input logic b, input logic [63:0] t, output expT e);
    logic mis;
    mis = 1'b0;
    if (b) begin
      mIfidPc    = 64'h0;
      mIfidInstr = NOP_INSTR;
      mIfidValid = 1'b0;
      if (TrapMode && (t % 4 != 0)) begin
        mPc    = TRAP_PC;
        mis    = 1'b1;
        mFault = t;
      end else begin
        mPc = t - (t % 4);
      end
    end else if (!s) begin
      mIfidPc    = mPc;
      mIfidInstr = memWord(mPc);
      mIfidValid = 1'b1;
      mPc        = mPc + 64'd4;
    end
    e = snapshot(mis);
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [63:0] t);
    expT e;
    @(negedge clk);
    Stall         = s;
    Branch_Taken  = b;
    Branch_Target = b ? t : {$urandom, $urandom};
    modelStep(s, b, t, e);
    expQ.push_back(e);
    @(posedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"},        Instruction_Address, RESET_PC);
    checkOutput({tag, "_ifidPc"},    IFID_PC, 64'h0);
    checkOutput({tag, "_ifidInstr"}, 64'(IFID_Instruction), 64'(NOP_INSTR));
    checkOutput({tag, "_ifidValid"}, 64'(IFID_Valid), 64'h0);
    checkOutput({tag, "_mis"},       64'(Misaligned_Fetch), 64'h0);
    checkOutput({tag, "_fault"},     Fault_Addr, 64'h0);
  endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge arrives
  task automatic resetPulse();
    @(negedge clk);
    Stall        = 1'b1;
    Branch_Taken = 1'b0;
    #2 reset_n = 1'b0;
    #1 checkResetValues("midReset");
    #1 reset_n = 1'b1;
    modelReset();
    expQ.push_back(snapshot(1'b0));
  endtask

  function automatic logic [63:0] randTarget();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'($urandom_range(0, 1023)) & ~64'h3;
      1:       t = (64'($urandom_range(0, 1023)) & ~64'h3) | 64'($urandom_range(1, 3));
      2:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  // Monitor: compare the DUT against the oldest pending expectation after each edge
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc",        Instruction_Address, e.pc);
        checkOutput("ifidPc",    IFID_PC, e.ifidPc);
        checkOutput("ifidInstr", 64'(IFID_Instruction), 64'(e.ifidInstr));
        checkOutput("ifidValid", 64'(IFID_Valid), 64'(e.ifidValid));
        checkOutput("misFetch",  64'(Misaligned_Fetch), 64'(e.mis));
        checkOutput("faultAddr", Fault_Addr, e.fault);
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic
  initial begin
    reset_n       = 1'b0;
    Stall         = 1'b1;
    Branch_Taken  = 1'b0;
    Branch_Target = 64'h0;
    modelReset();
    #12;
    checkResetValues("reset");
    reset_n = 1'b1;
    expQ.push_back(snapshot(1'b0));

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 64'h40);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h42);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h18);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    resetPulse();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0);

    for (int i = 0; i < 400; i++) begin
      logic s, b;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      applyStimulus(s, b, randTarget());
    end

    @(negedge clk);
    Stall        = 1'b1;
    Branch_Taken = 1'b0;
    @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
